// File: rtl/fmac_pkg.sv
// Shared defaults and width helpers for the fmac_pipe multiply-accumulate slice.
package fmac_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_ACC_W     = 24;
    localparam int unsigned DEF_THRESHOLD = 65025;
    localparam int unsigned DEF_FRAME_LEN = 4;

    // One guard bit above the accumulator so the threshold compare sees the carry.
    function automatic int unsigned sum_w(input int unsigned acc_w);
        return acc_w + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

endpackage

// File: rtl/fmac_mult_stage.sv
// S1 of fmac_pipe: registers the zero-extended product of an accepted sample.
module fmac_mult_stage
    import fmac_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              clear,
    input  logic              valid,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    output logic [ACC_W-1:0]  prod,
    output logic              s1_valid
);

    logic [2*DATA_W-1:0] prod_full;
    logic                take;

    always_comb begin
        prod_full = (2*DATA_W)'(x) * (2*DATA_W)'(y);
        take      = valid && !clear;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            prod     <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= take;
            if (take) begin
                prod <= ACC_W'(prod_full);
            end
        end
    end

endmodule

// File: rtl/fmac_pipe.sv
// Framed multiply-accumulate: S1 multiply, S2 accumulate with overflow handling.
// Define FMAC_PIPE_SAT_EN for saturating overflow with sticky ovf; default wraps to zero.
module fmac_pipe
    import fmac_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned THRESHOLD = DEF_THRESHOLD,
    parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  a,
    output logic              ovf
);

    localparam int unsigned      SUM_W   = sum_w(ACC_W);
    localparam int unsigned      CNT_W   = cnt_w(FRAME_LEN);
    localparam logic [SUM_W-1:0] THR_SUM = SUM_W'(THRESHOLD);
`ifdef FMAC_PIPE_SAT_EN
    localparam logic [ACC_W-1:0] THR_ACC = ACC_W'(THRESHOLD);
`endif

    logic [ACC_W-1:0] prod;
    logic             s1_valid;
    logic             s1_last;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum;
    logic             over;
    logic [ACC_W-1:0] upd_acc;
    logic             accept;
    logic             is_final;
    logic             s2_fin;
    logic             pend_valid;
    logic [ACC_W-1:0] pend_a;
    logic             xfer;

    always_comb begin
        in_ready = !(out_valid && !out_ready) && !(s1_valid && s1_last);
        accept   = in_valid && in_ready;
        // S1 only ever holds a non-final sample when a new one is accepted,
        // so the new sample's index is the processed count plus S1 occupancy.
        is_final = (({1'b0, cnt} + (CNT_W+1)'(s1_valid)) == (CNT_W+1)'(FRAME_LEN - 1));
    end

    fmac_mult_stage #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mult (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (clear),
        .valid    (accept),
        .x        (x),
        .y        (y),
        .prod     (prod),
        .s1_valid (s1_valid)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_last <= 1'b0;
        end else if (accept && !clear) begin
            s1_last <= is_final;
        end
    end

    always_comb begin
        sum  = SUM_W'(acc) + SUM_W'(prod);
        over = (sum > THR_SUM);
        if (over) begin
`ifdef FMAC_PIPE_SAT_EN
            upd_acc = THR_ACC;
`else
            upd_acc = '0;
`endif
        end else begin
            upd_acc = sum[ACC_W-1:0];
        end
        s2_fin = s1_valid && s1_last && !clear;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (s1_valid) begin
            if (s1_last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= upd_acc;
                cnt <= cnt + CNT_W'(1);
            end
`ifdef FMAC_PIPE_SAT_EN
            ovf <= s1_last ? 1'b0 : (ovf | over);
`else
            ovf <= over;
`endif
        end else begin
`ifndef FMAC_PIPE_SAT_EN
            ovf <= 1'b0;
`endif
        end
    end

    // The finished sum waits one cycle in pend_a before reaching a; in_ready
    // gating guarantees the holding slot is empty whenever S2 finishes a frame.
    always_comb begin
        xfer = pend_valid && (!out_valid || out_ready);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend_valid <= 1'b0;
            pend_a     <= '0;
            a          <= '0;
            out_valid  <= 1'b0;
        end else begin
            pend_valid <= s2_fin || (pend_valid && !xfer);
            if (s2_fin) begin
                pend_a <= upd_acc;
            end
            if (xfer) begin
                a         <= pend_a;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
